// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multi-cycle sequencer for the 8-bit processor datapath.
//                Steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
//                drives the datapath control lines, runs the req/ready
//                handshake with the shared memory, and provides halt, a
//                sticky fault (memory timeout / illegal opcode) and a
//                retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       inst,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             halt,
  output logic             mem_req,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             ALUSrc,
  output logic             Branch,
  output logic             Jump,
  output logic [1:0]       ALUOp,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [2:0]       c_op_rtype = 3'd0;
  localparam logic [2:0]       c_op_addi  = 3'd1;
  localparam logic [2:0]       c_op_lw    = 3'd2;
  localparam logic [2:0]       c_op_sw    = 3'd3;
  localparam logic [2:0]       c_op_beq   = 3'd4;
  localparam logic [2:0]       c_op_j     = 3'd5;
  // Last wait value before a further idle cycle trips the timeout.
  localparam logic [7:0]       c_wait_last = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_one       = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [2:0]       r_op;
  logic [7:0]       r_wait;
  logic             r_fault;
  logic [CNT_W-1:0] r_retired;
  state_t           w_next_fetch;
  logic             w_unused_inst;

  // Only the opcode field of the IR matters to the sequencer.
  assign w_unused_inst = ^inst[4:0];

  // A halt request diverts any return-to-fetch into HALT.
  assign w_next_fetch = halt ? S_HALT : S_FETCH;

  // State sequencing, opcode latch, wait counter, fault flag and retire count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_op      <= 3'd0;
      r_wait    <= 8'd0;
      r_fault   <= 1'b0;
      r_retired <= '0;
    end else begin
      // Counter is cleared whenever not actively waiting, so every entry to
      // FETCH/MEM starts from zero.
      r_wait <= 8'd0;
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_state <= S_DECODE;
          end else if (r_wait == c_wait_last) begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_DECODE: begin
          r_op <= inst[7:5];
          if (inst[7:6] == 2'b11) begin
            r_fault <= 1'b1;
            r_state <= w_next_fetch;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (r_op)
            c_op_rtype, c_op_addi: r_state <= S_WB;
            c_op_lw, c_op_sw:      r_state <= S_MEM;
            default: begin
              // beq and j complete here
              r_state   <= w_next_fetch;
              r_retired <= r_retired + c_one;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (r_op == c_op_lw) begin
              r_state <= S_WB;
            end else begin
              r_state   <= w_next_fetch;
              r_retired <= r_retired + c_one;
            end
          end else if (r_wait == c_wait_last) begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_WB: begin
          r_state   <= w_next_fetch;
          r_retired <= r_retired + c_one;
        end
        S_HALT: begin
          if (!halt) begin
            r_state <= S_FETCH;
          end
        end
        default: begin
          // FAULT parks until reset
          r_state <= S_FAULT;
        end
      endcase
    end
  end

  // Control decode from state and latched opcode; gated by reset so that an
  // in-flight request drops the instant reset asserts.
  always_comb begin
    mem_req  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUSrc   = 1'b0;
    Branch   = 1'b0;
    Jump     = 1'b0;
    ALUOp    = 2'b00;
    if (reset) begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          MemRead = 1'b1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_EXEC: begin
          case (r_op)
            c_op_rtype: ALUOp = 2'b10;
            c_op_addi, c_op_lw, c_op_sw: ALUSrc = 1'b1;
            c_op_beq: begin
              ALUOp   = 2'b01;
              Branch  = 1'b1;
              PCWrite = zero;
              PCSrc   = 1'b1;
            end
            c_op_j: begin
              Jump    = 1'b1;
              PCWrite = 1'b1;
              PCSrc   = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req  = 1'b1;
          ALUSrc   = 1'b1;
          MemRead  = (r_op == c_op_lw);
          MemWrite = (r_op == c_op_sw);
        end
        S_WB: begin
          RegWrite = 1'b1;
          RegDst   = (r_op == c_op_rtype);
          MemtoReg = (r_op == c_op_lw);
          ALUSrc   = (r_op == c_op_addi);
        end
        default: ;
      endcase
    end
  end

  assign halted  = reset && (r_state == S_HALT);
  assign fault   = r_fault;
  assign retired = r_retired;

endmodule
`default_nettype wire
